// File: rtl/tx_pkg.sv
// Shared state encoding and CRC-16/CCITT constants for the backscatter reply sequencer.
package tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_DATA,
      ST_CRC,
      ST_EOS,
      ST_DONE
   } tx_state_t;

   localparam logic [15:0] CRC16_POLY   = 16'h1021;
   localparam logic [15:0] CRC16_PRESET = 16'hFFFF;

   // One bit of the MSB-first serial CRC update.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16/CCITT remainder; only built when TX_CRC16_EN is defined.
`ifdef TX_CRC16_EN
module crc16_serial
   import tx_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        init,
   input  logic        enable,
   input  logic        din,
   output logic [15:0] crc
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      crc <= CRC16_PRESET;
      else if (init)   crc <= CRC16_PRESET;
      else if (enable) crc <= crc16_step(crc, din);
   end

endmodule
`endif

// File: rtl/tx_sequencer.sv
// Tag reply sequencer: preamble, data bits, optional CRC-16 (TX_CRC16_EN), end-of-signalling 1.
// One symbol per clk; drives the preamble generator reset and muxes its symbols onto out.
module tx_sequencer
   import tx_pkg::*;
#(
   parameter int unsigned      CNT_W    = 16,
   parameter logic [CNT_W-1:0] MAX_BITS = 16'd512
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       m,
   input  logic             trext,
   input  logic             pre_out,
   input  logic             pre_violation,
   input  logic             pre_done,
   output logic             pre_reset,
   output logic [1:0]       m_q,
   output logic             trext_q,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             last_bit,
   output logic             bit_ack,
   output logic             out,
   output logic             violation,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] bit_count
);

   tx_state_t state, state_nxt;
   logic      sym_q, sym_nxt;
   logic      stop_q;     // sym_q holds the final data bit (last_bit or limit)
   logic      abort_q;    // that final bit hit the limit without last_bit
   logic      accept, underflow, at_limit, start_ok;

   assign start_ok = (state == ST_IDLE) && start;
   assign at_limit = (bit_count == MAX_BITS - 1'b1);

`ifdef TX_CRC16_EN
   logic [15:0] crc_rem;
   logic [3:0]  crc_idx;

   crc16_serial u_crc (
      .clk    (clk),
      .reset  (reset),
      .init   (start_ok),
      .enable (accept),
      .din    (bit_in),
      .crc    (crc_rem)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                crc_idx <= '0;
      else if (state == ST_CRC)  crc_idx <= crc_idx + 1'b1;
      else                       crc_idx <= '0;
   end
`endif

   // NOTE: every output and next-state signal gets a default first so no path infers a latch.
   always_comb begin
      state_nxt = state;
      sym_nxt   = sym_q;
      pre_reset = 1'b0;
      out       = sym_q;
      violation = 1'b0;
      bit_ack   = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      accept    = 1'b0;
      underflow = 1'b0;
      case (state)
         ST_IDLE: begin
            pre_reset = 1'b1;
            busy      = 1'b0;
            out       = 1'b0;
            if (start) state_nxt = ST_PRE;
         end
         ST_PRE: begin
            out       = pre_out;
            violation = pre_violation;
            if (pre_done) begin
               if (bit_valid) begin
                  accept    = 1'b1;
                  state_nxt = ST_DATA;
               end else begin
                  underflow = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (stop_q) begin
               if (abort_q) begin
                  state_nxt = ST_DONE;
               end else begin
`ifdef TX_CRC16_EN
                  state_nxt = ST_CRC;
                  sym_nxt   = ~crc_rem[15];
`else
                  state_nxt = ST_EOS;
                  sym_nxt   = 1'b1;
`endif
               end
            end else if (bit_valid) begin
               accept = 1'b1;
            end else begin
               underflow = 1'b1;
            end
         end
`ifdef TX_CRC16_EN
         ST_CRC: begin
            if (crc_idx == 4'd15) begin
               state_nxt = ST_EOS;
               sym_nxt   = 1'b1;
            end else begin
               sym_nxt = ~crc_rem[4'd14 - crc_idx];
            end
         end
`endif
         ST_EOS:  state_nxt = ST_DONE;
         ST_DONE: begin
            out       = 1'b0;
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (accept) begin
         bit_ack = 1'b1;
         sym_nxt = bit_in;
      end
      if (underflow) begin
         out       = 1'b0;
         state_nxt = ST_DONE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         sym_q     <= 1'b0;
         stop_q    <= 1'b0;
         abort_q   <= 1'b0;
         error     <= 1'b0;
         bit_count <= '0;
         m_q       <= 2'd0;
         trext_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         sym_q <= sym_nxt;
         if (start_ok) begin
            m_q       <= m;
            trext_q   <= trext;
            bit_count <= '0;
            error     <= 1'b0;
            stop_q    <= 1'b0;
            abort_q   <= 1'b0;
         end
         if (accept) begin
            if (bit_count != {CNT_W{1'b1}}) bit_count <= bit_count + 1'b1;
            stop_q  <= last_bit || at_limit;
            abort_q <= at_limit && !last_bit;
         end
         if (underflow || (state == ST_DATA && stop_q && abort_q)) error <= 1'b1;
      end
   end

endmodule

// File: doc/tx_sequencer.md
Name: tx_sequencer

Overview:
- Sequences one tag backscatter reply: a preamble, then the data bits, then an optional CRC-16, then the end-of-signalling dummy 1.
- Controls the reset of the external preamble generator and muxes its `out`/`violation` onto the transmit symbol stream.
- Pulls data bits from an upstream bit source through a valid/ack handshake.
- Sits between the reply-building logic and the Miller/FM0 modulator; one symbol per `clk` (bit clock).

Parameters:
- CNT_W, 16, width of the data-bit counter.
- MAX_BITS, 16'd512, data-bit limit; reaching it without `last_bit` aborts the reply.

Ports:
- clk  in  1  bit-rate clock
- reset  in  1  asynchronous reset, active-low (asserted when 0)
- start  in  1  one-cycle request to send a reply; honoured only in IDLE
- m  in  2  encoding select (0 = FM0, else Miller); sampled at start, held internally
- trext  in  1  pilot-tone select; sampled at start, held internally
- pre_out  in  1  preamble generator symbol
- pre_violation  in  1  preamble generator violation flag
- pre_done  in  1  preamble generator done
- pre_reset  out  1  active-high reset to preamble generator
- m_q  out  2  latched m, drives the preamble generator
- trext_q  out  1  latched trext, drives the preamble generator
- bit_valid  in  1  upstream bit available
- bit_in  in  1  upstream data bit
- last_bit  in  1  qualifies bit_in as final data bit
- bit_ack  out  1  upstream bit consumed this cycle
- out  out  1  transmit symbol to modulator
- violation  out  1  violation flag to modulator
- busy  out  1  high in every state but IDLE
- done  out  1  one-cycle pulse at end of reply
- error  out  1  sticky abort flag; cleared by next accepted start
- bit_count  out  CNT_W  data bits accepted this reply

Behaviour:
- States:
  - IDLE: pre_reset=1. On start, latch m/trext, clear bit_count and error, then go to PRE.
  - PRE: pre_reset=0; out=pre_out, violation=pre_violation (combinational pass-through).
  - DATA, CRC, EOS: out=sym_q (registered), violation=0.
  - DONE: out=0, violation=0, done=1 for exactly one cycle, then IDLE.
- Reset values: out=0, violation=0, pre_reset=1, bit_ack=0, busy=0, done=0, error=0, bit_count=0, m_q=0, trext_q=0, state IDLE.
- PRE→DATA: in the cycle pre_done=1 (last preamble symbol on out), the sequencer samples the bit source.
  - bit_valid=1: bit_ack=1, sym_q<=bit_in, next state DATA. This is gap-free: the first data bit is on out the following cycle.
  - bit_valid=0: underflow.
- DATA, each cycle:
  - If bit_valid=1: bit_ack=1, sym_q<=bit_in, bit_count+1.
  - If the accepted bit has last_bit=1: next state is CRC (feature on) or EOS, and sym_q for the first CRC/EOS cycle is loaded that same edge.
- Underflow (bit_valid=0 when a bit is required): error<=1, out forced 0, go to DONE.
- Limit: bit_count reaching MAX_BITS without last_bit sets error<=1 and goes to DONE after that bit is sent.
- bit_count saturates and never wraps.
- EOS: sym_q=1 for exactly one cycle, then DONE.
- bit_ack is combinational from state and bit_valid; it is asserted only in PRE(pre_done) and DATA.
- start while busy: ignored, no effect.
- reset asserted mid-reply: immediate return to IDLE with reset values; preamble generator reset via pre_reset.
- Preamble length in cycles from PRE entry to pre_done, for checking:
  - m=0: 6 (trext=0), 18 (trext=1)
  - m>0: 10 (trext=0), 22 (trext=1)

Optional Feature:
- TX_CRC16_EN defined:
  - CRC-16/CCITT (poly 0x1021, preset 0xFFFF) runs over every accepted data bit.
  - CRC state: 16 cycles sending the ones-complement of the register, MSB first, then EOS.
- TX_CRC16_EN undefined: CRC state and register absent; DATA goes directly to EOS.

Decomposition:
- Shared package `tx_pkg`: state encoding typedef, CRC16_POLY=16'h1021, CRC16_PRESET=16'hFFFF.
- One natural sub-module, `crc16_serial`: init, enable, bit in → 16-bit remainder. Instantiated only under TX_CRC16_EN.

Test Plan:
- m=0, trext=0, start; bits 1,0,1 (last on third), bit_valid always 1.
  - pre_done on 6th cycle; out then 1,0,1, EOS 1, done pulse; bit_count=3, error=0.
- m=2, trext=1, start; single bit 0 with last.
  - 22 preamble cycles with violation copied from pre_violation; out 0 then 1; done after 25 cycles total; busy high throughout.
- bit_valid low when pre_done=1.
  - bit_ack=0, error=1, out 0, done next cycle, bit_count=0.
- start pulsed during DATA, and reset driven low mid-DATA.
  - start has no effect; reset returns to IDLE immediately with pre_reset=1, out=0, busy=0, error=0.
- MAX_BITS=4, five bits without last.
  - exactly 4 bit_acks, error=1, done pulse, bit_count=4.
- TX_CRC16_EN, m=0, data 8'h00 with last.
  - after data, out carries ~CRC over 0x00 (16 bits, MSB first), then EOS 1.
